// File: rtl/register_bank_if.sv
// Bus-side signals of the register bank: load strobes, shared data bus, PC control,
// read select, and the registered views the bank drives back.
interface register_bank_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8
);
    localparam int SELW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0]       rin;
    logic [WIDTH-1:0]          buswires;
    logic                      incr_pc;
    logic [SELW-1:0]           rsel;
    logic [NUM_REGS*WIDTH-1:0] r_all;
    logic [WIDTH-1:0]          rdata;
    logic [WIDTH-1:0]          pc;
    logic                      pc_wrap;

    modport master (
        output rin, buswires, incr_pc, rsel,
        input  r_all, rdata, pc, pc_wrap
    );

    modport slave (
        input  rin, buswires, incr_pc, rsel,
        output r_all, rdata, pc, pc_wrap
    );
endinterface

// File: rtl/register_bank.sv
// Purpose: NUM_REGS-entry register bank; top entry is the PC with self-increment and wrap pulse.
// Latency: loads, PC step, rdata and pc_wrap all land one clock after the driving edge.
// Backpressure: none; every strobe is accepted each cycle. Option: REG_BANK_WRITE_BYPASS_EN.
module register_bank #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int RESET_PC = 0
) (
    input  logic             clock,
    input  logic             resetn,
    register_bank_if.slave   bus
);
    localparam int              SELW       = $clog2(NUM_REGS);
    localparam int              PCI        = NUM_REGS - 1;
    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [SELW:0]   NUM_REGS_W = (SELW + 1)'(NUM_REGS);
    localparam logic [SELW-1:0] PC_SEL     = SELW'(PCI);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] rdata_q;
    logic             pc_wrap_q;

    logic [WIDTH-1:0] pc_inc;
    logic             pc_step;
    logic             wrap_next;
    logic [WIDTH-1:0] rd_next;

    // A load of the PC in the same cycle takes priority over the increment.
    always_comb begin
        pc_inc    = regs[PCI] + 1'b1;
        pc_step   = bus.incr_pc & ~bus.rin[PCI];
        wrap_next = pc_step & (&regs[PCI]);
    end

    always_comb begin
        rd_next = '0;
        if ({1'b0, bus.rsel} < NUM_REGS_W) begin
            rd_next = regs[bus.rsel];
`ifdef REG_BANK_WRITE_BYPASS_EN
            if (bus.rin[bus.rsel]) begin
                rd_next = bus.buswires;
            end else if ((bus.rsel == PC_SEL) && pc_step) begin
                rd_next = pc_inc;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
            regs[PCI] <= RESET_PC_W;
            rdata_q   <= '0;
            pc_wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.rin[i]) begin
                    regs[i] <= bus.buswires;
                end
            end
            if (pc_step) begin
                regs[PCI] <= pc_inc;
            end
            rdata_q   <= rd_next;
            pc_wrap_q <= wrap_next;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign bus.r_all[g*WIDTH +: WIDTH] = regs[g];
    end

    assign bus.pc      = regs[PCI];
    assign bus.rdata   = rdata_q;
    assign bus.pc_wrap = pc_wrap_q;
endmodule

// File: tb/tb_register_bank.sv
// Directed-vector bench for register_bank: an 8-entry bank with a non-zero reset PC,
// plus a 5-entry bank to reach read selects beyond the last register.
module tb_register_bank;
    logic clock;
    logic resetn;

    int tests  = 0;
    int failed = 0;

`ifdef REG_BANK_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    register_bank_if #(.WIDTH(16), .NUM_REGS(8)) m ();
    register_bank_if #(.WIDTH(16), .NUM_REGS(5)) s ();

    register_bank #(.WIDTH(16), .NUM_REGS(8), .RESET_PC(16'h0100)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (m.slave)
    );

    register_bank #(.WIDTH(16), .NUM_REGS(5), .RESET_PC(0)) dut5 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (s.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [7:0]  rin;
        logic [15:0] bus;
        logic        incr;
        logic [2:0]  rsel;
        logic [15:0] exp_pc;
        logic        exp_wrap;
        logic [15:0] exp_rdata;
        int          chk;
        logic [15:0] exp_reg;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] rd(input logic [15:0] old_v, input logic [15:0] new_v);
        return BYP ? new_v : old_v;
    endfunction

    function automatic logic [15:0] reg_of(input int i);
        return m.r_all[i*16 +: 16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // rin, bus, incr, rsel, exp_pc, exp_wrap, exp_rdata, chk, exp_reg
        vecs[0]  = '{8'h04, 16'habcd, 1'b0, 3'd2, 16'h0100, 1'b0, rd(16'h0000, 16'habcd), 2, 16'habcd};
        vecs[1]  = '{8'h00, 16'h000f, 1'b0, 3'd2, 16'h0100, 1'b0, 16'habcd,               2, 16'habcd};
        vecs[2]  = '{8'h00, 16'h0000, 1'b1, 3'd7, 16'h0101, 1'b0, rd(16'h0100, 16'h0101), 0, 16'h0000};
        vecs[3]  = '{8'h80, 16'hffff, 1'b0, 3'd2, 16'hffff, 1'b0, 16'habcd,               7, 16'hffff};
        vecs[4]  = '{8'h00, 16'h0000, 1'b1, 3'd7, 16'h0000, 1'b1, rd(16'hffff, 16'h0000), 2, 16'habcd};
        vecs[5]  = '{8'h00, 16'h0000, 1'b1, 3'd7, 16'h0001, 1'b0, rd(16'h0000, 16'h0001), 1, 16'h0000};
        vecs[6]  = '{8'h80, 16'h1234, 1'b1, 3'd0, 16'h1234, 1'b0, 16'h0000,               3, 16'h0000};
        vecs[7]  = '{8'h08, 16'h5a5a, 1'b0, 3'd7, 16'h1234, 1'b0, 16'h1234,               3, 16'h5a5a};
        vecs[8]  = '{8'h08, 16'hc3c3, 1'b0, 3'd3, 16'h1234, 1'b0, rd(16'h5a5a, 16'hc3c3), 3, 16'hc3c3};
        vecs[9]  = '{8'h00, 16'h0000, 1'b0, 3'd3, 16'h1234, 1'b0, 16'hc3c3,               3, 16'hc3c3};
        vecs[10] = '{8'h21, 16'hbeef, 1'b0, 3'd5, 16'h1234, 1'b0, rd(16'h0000, 16'hbeef), 0, 16'hbeef};
        vecs[11] = '{8'h00, 16'h1111, 1'b0, 3'd5, 16'h1234, 1'b0, 16'hbeef,               5, 16'hbeef};
        vecs[12] = '{8'h80, 16'hffff, 1'b1, 3'd0, 16'hffff, 1'b0, 16'hbeef,               6, 16'h0000};
        vecs[13] = '{8'h00, 16'h0000, 1'b0, 3'd1, 16'hffff, 1'b0, 16'h0000,               1, 16'h0000};

        m.rin = '0; m.buswires = '0; m.incr_pc = 1'b0; m.rsel = '0;
        s.rin = '0; s.buswires = '0; s.incr_pc = 1'b0; s.rsel = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #20;

        // Reset state
        for (int i = 0; i < 7; i++) check($sformatf("reset r%0d", i), 32'(reg_of(i)), 32'h0);
        check("reset pc", 32'(m.pc), 32'h0100);
        check("reset r_all pc", 32'(reg_of(7)), 32'h0100);
        check("reset rdata", 32'(m.rdata), 32'h0);
        check("reset pc_wrap", 32'(m.pc_wrap), 32'h0);

        resetn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            m.rin = vecs[i].rin; m.buswires = vecs[i].bus;
            m.incr_pc = vecs[i].incr; m.rsel = vecs[i].rsel;
            tick();
            check($sformatf("v%0d pc", i), 32'(m.pc), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d pc_wrap", i), 32'(m.pc_wrap), 32'(vecs[i].exp_wrap));
            check($sformatf("v%0d rdata", i), 32'(m.rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d r%0d", i, vecs[i].chk), 32'(reg_of(vecs[i].chk)), 32'(vecs[i].exp_reg));
        end
        m.rin = '0; m.incr_pc = 1'b0;

        // Read selects beyond the last register return zero
        s.rin = 5'h1f; s.buswires = 16'h7777; s.rsel = 3'd4;
        tick();
        check("s5 rdata old pc", 32'(s.rdata), 32'(rd(16'h0000, 16'h7777)));
        s.rin = '0; s.rsel = 3'd5;
        tick();
        check("s5 rsel5 rdata", 32'(s.rdata), 32'h0);
        s.rsel = 3'd7;
        tick();
        check("s5 rsel7 rdata", 32'(s.rdata), 32'h0);
        s.rsel = 3'd4;
        tick();
        check("s5 rsel4 rdata", 32'(s.rdata), 32'h7777);

        // Async reset while PC=ffff is incrementing: no wrap pulse
        m.incr_pc = 1'b1; m.rsel = 3'd7;
        #3 resetn = 1'b0;
        #1;
        check("arst pc", 32'(m.pc), 32'h0100);
        check("arst pc_wrap", 32'(m.pc_wrap), 32'h0);
        check("arst rdata", 32'(m.rdata), 32'h0);
        check("arst r0", 32'(reg_of(0)), 32'h0);
        check("arst r3", 32'(reg_of(3)), 32'h0);
        tick();
        check("arst hold pc", 32'(m.pc), 32'h0100);
        check("arst hold pc_wrap", 32'(m.pc_wrap), 32'h0);
        #2 resetn = 1'b1;
        tick();
        check("resume pc", 32'(m.pc), 32'h0101);
        check("resume pc_wrap", 32'(m.pc_wrap), 32'h0);
        check("resume rdata", 32'(m.rdata), 32'(rd(16'h0100, 16'h0101)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
